// File: rtl/beep_sequencer_pkg.sv
// Shared definitions for the beep sequencer: state encoding, counter width
// and the hour-to-beep-count mapping used by the hourly chime.
package beep_sequencer_pkg;

  localparam int CNT_W = 8;

  // Chime count used for midnight/noon and any out-of-range hour value
  localparam logic [CNT_W-1:0] HOUR_MAP = CNT_W'(12);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_t;

  // Hour 0 and hours above 12 chime twelve times; 1..12 chime their own value
  function automatic logic [CNT_W-1:0] map_hour(input logic [3:0] h);
    if (h == 4'd0 || h > 4'd12) return HOUR_MAP;
    return CNT_W'(h);
  endfunction

endpackage

// File: rtl/beep_sequencer_phase_timer.sv
// beep_phase_timer: counts tick strobes within one on/off phase.
// o_tc flags the tick that completes the phase (count reaches i_terminal).
// i_clear has priority over a tick in the same cycle, so a tick arriving in
// the cycle the phase changes is not carried into the next phase.
module beep_phase_timer
  import beep_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_tick,
  input  logic [CNT_W-1:0] i_terminal,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_cnt;

  // Terminal tick: this tick brings the phase count up to i_terminal
  assign o_tc = i_tick && (r_cnt >= (i_terminal - CNT_W'(1)));

  // Tick counter, cleared on phase change, saturating instead of wrapping
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_cnt <= '0;
    end else if (i_tick && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/beep_sequencer.sv
// beep_sequencer: drives a beep controller with hourly chime and alarm
// patterns made of alternating on/off phases timed by tick strobes.
// Optional build macro BEEP_SEQUENCER_QUIET_EN adds input 'quiet' which
// suppresses new chimes (alarms still run).
module beep_sequencer
  import beep_sequencer_pkg::*;
#(
  parameter int ON_TICKS    = 4,
  parameter int OFF_TICKS   = 4,
  parameter int ALARM_BEEPS = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       chime_trig,
  input  logic [3:0] hour,
  input  logic       alarm_trig,
  input  logic       stop,
`ifdef BEEP_SEQUENCER_QUIET_EN
  input  logic       quiet,
`endif
  output logic       beep,
  output logic       beep_enabled,
  output logic       busy,
  output logic       alarm_active
);

  localparam logic [CNT_W-1:0] ON_T    = CNT_W'(ON_TICKS);
  localparam logic [CNT_W-1:0] OFF_T   = CNT_W'(OFF_TICKS);
  localparam logic [CNT_W-1:0] ALARM_N = CNT_W'(ALARM_BEEPS);

  state_t           r_state;
  logic [CNT_W-1:0] r_remaining;
  logic             r_beep;
  logic             r_beep_en;
  logic             r_busy;
  logic             r_alarm;

  logic             w_chime_req;
  logic             w_alarm_go;
  logic             w_chime_go;
  logic             w_tc;
  logic             w_phase_done;
  logic             w_clear;
  logic [CNT_W-1:0] w_terminal;

`ifdef BEEP_SEQUENCER_QUIET_EN
  assign w_chime_req = chime_trig && !quiet;
`else
  assign w_chime_req = chime_trig;
`endif

  // An alarm starts from idle or pre-empts a chime; a running alarm is not restarted
  assign w_alarm_go   = alarm_trig && !r_alarm;
  assign w_chime_go   = w_chime_req && (r_state == ST_IDLE);
  assign w_phase_done = w_tc && (r_state != ST_IDLE);

  // Every path that changes state also restarts the phase count
  assign w_clear    = stop || (r_state == ST_IDLE) || w_alarm_go || w_phase_done;
  assign w_terminal = (r_state == ST_OFF) ? OFF_T : ON_T;

  beep_phase_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (w_clear),
    .i_tick     (tick),
    .i_terminal (w_terminal),
    .o_tc       (w_tc)
  );

  // Pattern FSM with registered outputs; priority rst > stop > alarm > chime > phase end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
      r_beep      <= 1'b0;
      r_beep_en   <= 1'b0;
      r_busy      <= 1'b0;
      r_alarm     <= 1'b0;
    end else begin
      r_beep <= 1'b0;
      if (stop) begin
        r_state     <= ST_IDLE;
        r_remaining <= '0;
        r_beep_en   <= 1'b0;
        r_busy      <= 1'b0;
        r_alarm     <= 1'b0;
      end else if (w_alarm_go) begin
        r_state     <= ST_ON;
        r_remaining <= ALARM_N;
        r_beep      <= 1'b1;
        r_beep_en   <= 1'b1;
        r_busy      <= 1'b1;
        r_alarm     <= 1'b1;
      end else if (w_chime_go) begin
        r_state     <= ST_ON;
        r_remaining <= map_hour(hour);
        r_beep      <= 1'b1;
        r_beep_en   <= 1'b1;
        r_busy      <= 1'b1;
      end else if (w_phase_done) begin
        case (r_state)
          ST_ON: begin
            r_state   <= ST_OFF;
            r_beep_en <= 1'b0;
            if (r_remaining != '0) begin
              r_remaining <= r_remaining - CNT_W'(1);
            end
          end
          ST_OFF: begin
            if (r_remaining != '0) begin
              r_state   <= ST_ON;
              r_beep    <= 1'b1;
              r_beep_en <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
              r_alarm <= 1'b0;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_alarm <= 1'b0;
          end
        endcase
      end
    end
  end

  assign beep         = r_beep;
  assign beep_enabled = r_beep_en;
  assign busy         = r_busy;
  assign alarm_active = r_alarm;

endmodule

// File: tb/tb_beep_sequencer.sv
// Testbench for beep_sequencer (ON_TICKS=OFF_TICKS=2, ALARM_BEEPS=5).
module tb_beep_sequencer;

  localparam int ON_T = 2;
  localparam int OFF_T = 2;
  localparam int AB = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       chime_trig = 1'b0;
  logic [3:0] hour = 4'd0;
  logic       alarm_trig = 1'b0;
  logic       stop = 1'b0;
`ifdef BEEP_SEQUENCER_QUIET_EN
  logic       quiet = 1'b0;
`endif
  logic       beep;
  logic       beep_enabled;
  logic       busy;
  logic       alarm_active;

  beep_sequencer #(
    .ON_TICKS    (ON_T),
    .OFF_TICKS   (OFF_T),
    .ALARM_BEEPS (AB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .chime_trig   (chime_trig),
    .hour         (hour),
    .alarm_trig   (alarm_trig),
    .stop         (stop),
`ifdef BEEP_SEQUENCER_QUIET_EN
    .quiet        (quiet),
`endif
    .beep         (beep),
    .beep_enabled (beep_enabled),
    .busy         (busy),
    .alarm_active (alarm_active)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Tick strobe: one cycle high out of every three
  int tdiv = 0;
  initial begin
    forever begin
      @(negedge clk);
      tick = (tdiv == 0);
      tdiv = (tdiv == 2) ? 0 : tdiv + 1;
    end
  end

  // Monitor: beep pulses, on-phase tick counts, alarm flag while busy
  int   n_beep = 0;
  int   n_noalarm = 0;
  int   on_ticks = 0;
  bit   ph_chk = 1'b1;
  logic last_en = 1'b0;
  logic last_beep = 1'b0;

  always @(posedge clk) begin
    #1;
    if (last_en === 1'b1 && tick) on_ticks++;
    if (ph_chk && last_en === 1'b1 && beep_enabled === 1'b0) chk("on_ticks", on_ticks, ON_T);
    if (beep === 1'b1) begin
      n_beep++;
      on_ticks = 0;
      chk("beep_with_en", int'(beep_enabled), 1);
      chk("beep_1cyc", int'(last_beep), 0);
    end
    if (busy === 1'b1 && alarm_active !== 1'b1) n_noalarm++;
    last_en   = beep_enabled;
    last_beep = beep;
  end

  // Scoreboard of expected pattern outcomes
  typedef struct {
    string tag;
    int    base;
    int    nal_base;
    int    beeps;
    bit    alarm;
  } exp_t;
  exp_t exp_q[$];

  task automatic sb_push(input string tag, input int beeps, input bit alarm);
    exp_t e;
    e.tag = tag; e.base = n_beep; e.nal_base = n_noalarm;
    e.beeps = beeps; e.alarm = alarm;
    exp_q.push_back(e);
  endtask

  task automatic expect_end(input int bound);
    exp_t e;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    e = exp_q.pop_front();
    chk({e.tag, "_busy_end"}, int'(busy), 0);
    chk({e.tag, "_beeps"}, n_beep - e.base, e.beeps);
    chk({e.tag, "_alarm_end"}, int'(alarm_active), 0);
    if (e.alarm) chk({e.tag, "_alarm_held"}, n_noalarm - e.nal_base, 0);
  endtask

  // Drive a trigger for one cycle and check the first-cycle response
  task automatic trig(input logic a, input logic c, input logic [3:0] h,
                      input logic exp_al, input string tag);
    @(negedge clk);
    alarm_trig = a; chime_trig = c; hour = h;
    @(posedge clk); #2;
    chk({tag, "_beep"}, int'(beep), 1);
    chk({tag, "_en"}, int'(beep_enabled), 1);
    chk({tag, "_busy"}, int'(busy), 1);
    chk({tag, "_alarm"}, int'(alarm_active), int'(exp_al));
    @(negedge clk);
    alarm_trig = 1'b0; chime_trig = 1'b0;
  endtask

  task automatic pulse(input logic a, input logic c, input logic [3:0] h);
    @(negedge clk);
    alarm_trig = a; chime_trig = c; hour = h;
    @(negedge clk);
    alarm_trig = 1'b0; chime_trig = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b;
    repeat (3) @(negedge clk);
    chk("rst_beep", int'(beep), 0);
    chk("rst_en", int'(beep_enabled), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_alarm", int'(alarm_active), 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Chimes, including the hour mapping boundaries
    sb_push("ch3", 3, 0);  trig(0, 1, 4'd3, 0, "ch3");   expect_end(1000);
    sb_push("ch0", 12, 0); trig(0, 1, 4'd0, 0, "ch0");   expect_end(2000);
    sb_push("ch13", 12, 0); trig(0, 1, 4'd13, 0, "ch13"); expect_end(2000);
    sb_push("ch1", 1, 0);  trig(0, 1, 4'd1, 0, "ch1");   expect_end(500);
    sb_push("ch12", 12, 0); trig(0, 1, 4'd12, 0, "ch12"); expect_end(2000);

    // Alarm, and alarm winning over a simultaneous chime
    sb_push("al", AB, 1);   trig(1, 0, 4'd0, 1, "al");    expect_end(1000);
    sb_push("alch", AB, 1); trig(1, 1, 4'd3, 1, "alch");  expect_end(1000);

    // Retriggers while busy are ignored
    sb_push("ch_ign", 2, 0); trig(0, 1, 4'd2, 0, "ch_ign");
    repeat (8) @(negedge clk); pulse(0, 1, 4'd9); expect_end(1000);
    sb_push("al_ign", AB, 1); trig(1, 0, 4'd0, 1, "al_ign");
    repeat (8) @(negedge clk); pulse(1, 0, 4'd0); expect_end(1000);

    // Alarm pre-empts a running chime after its second beep
    sb_push("preempt", 2 + AB, 0);
    b = n_beep;
    trig(0, 1, 4'd6, 0, "pre_ch");
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (n_beep - b >= 2) break;
    end
    repeat (2) @(negedge clk);
    trig(1, 0, 4'd0, 1, "pre_al");
    expect_end(1000);

    // Stop together with a chime request aborts the alarm
    sb_push("stop", 1, 1);
    trig(1, 0, 4'd0, 1, "st");
    repeat (2) @(negedge clk);
    ph_chk = 1'b0;
    stop = 1'b1; chime_trig = 1'b1; hour = 4'd5;
    @(posedge clk); #2;
    chk("st_beep", int'(beep), 0);
    chk("st_en", int'(beep_enabled), 0);
    chk("st_busy", int'(busy), 0);
    chk("st_alarm", int'(alarm_active), 0);
    @(negedge clk);
    stop = 1'b0; chime_trig = 1'b0;
    repeat (10) @(negedge clk);
    chk("st_stay_idle", int'(busy), 0);
    expect_end(10);
    ph_chk = 1'b1;

    // Reset during an on-phase aborts silently
    sb_push("rst_mid", 1, 0);
    trig(0, 1, 4'd4, 0, "rm");
    ph_chk = 1'b0;
    rst = 1'b1;
    @(posedge clk); #2;
    chk("rm_beep", int'(beep), 0);
    chk("rm_en", int'(beep_enabled), 0);
    chk("rm_busy", int'(busy), 0);
    chk("rm_alarm", int'(alarm_active), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    expect_end(10);
    ph_chk = 1'b1;

`ifdef BEEP_SEQUENCER_QUIET_EN
    // Quiet blocks chimes but not alarms
    quiet = 1'b1;
    pulse(0, 1, 4'd3);
    repeat (10) @(negedge clk);
    chk("quiet_busy", int'(busy), 0);
    sb_push("quiet_al", AB, 1); trig(1, 0, 4'd0, 1, "q_al"); expect_end(1000);
    quiet = 1'b0;
`endif

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/beep_sequencer.md
BEEP_SEQUENCER -- requirements
Module: beep_sequencer

Interface
REQ-001 Parameter ON_TICKS, default 4, SHALL set the number of tick strobes per beep-on phase (1..255).
REQ-002 Parameter OFF_TICKS, default 4, SHALL set the number of tick strobes per silent phase (1..255).
REQ-003 Parameter ALARM_BEEPS, default 60, SHALL set the number of beeps in one alarm pattern (1..255).
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-006 tick  input  1  SHALL be a one-cycle timebase strobe.
REQ-007 chime_trig  input  1  SHALL be a one-cycle request for an hourly chime.
REQ-008 hour  input  4  SHALL be the chime count source, sampled with chime_trig.
REQ-009 alarm_trig  input  1  SHALL be a one-cycle request for an alarm pattern.
REQ-010 stop  input  1  SHALL be a user acknowledge that aborts any pattern.
REQ-011 beep  output  1  SHALL be a one-cycle strobe at the start of each on-phase, feeding the beep controller's beep input.
REQ-012 beep_enabled  output  1  SHALL be high exactly during on-phases, feeding the beep controller's beep_enabled input.
REQ-013 busy  output  1  SHALL be high whenever the state is not IDLE.
REQ-014 alarm_active  output  1  SHALL be high while an alarm pattern runs.

Function
REQ-015 FSM states SHALL be IDLE, ON, OFF.
REQ-016 IDLE + alarm_trig at cycle t SHALL enter ON at t+1, load remaining = ALARM_BEEPS, set alarm_active.
REQ-017 IDLE + chime_trig (no alarm_trig) at cycle t SHALL enter ON at t+1 with remaining = hour, hour 0 or >12 mapped to 12.
REQ-018 beep SHALL pulse for exactly one cycle on every cycle in which the FSM enters ON.
REQ-019 In ON, a phase counter SHALL count tick strobes; on the ON_TICKS-th tick go to OFF and decrement remaining.
REQ-020 In OFF, on the OFF_TICKS-th tick, SHALL go to ON if remaining > 0, else IDLE.
REQ-021 Phase counter SHALL clear on every state transition; ticks in the transition cycle SHALL NOT carry over.
REQ-022 stop SHALL force IDLE on the next cycle from any state, clear remaining and alarm_active, and win over simultaneous triggers.
REQ-023 alarm_trig during a chime SHALL abort the chime and restart as an alarm entering ON next cycle (beep pulses).
REQ-024 chime_trig while busy SHALL be ignored; alarm_trig during an alarm SHALL be ignored.
REQ-025 Simultaneous alarm_trig and chime_trig in IDLE SHALL start the alarm.
REQ-026 Counters SHALL be 8 bit, never wrap; remaining SHALL saturate at 0.

Reset
REQ-027 rst high SHALL on the next edge set IDLE, beep=0, beep_enabled=0, busy=0, alarm_active=0, all counters 0.
REQ-028 rst mid-pattern SHALL abort silently with no further beep pulse.

Configuration
REQ-029 With BEEP_SEQUENCER_QUIET_EN defined, input quiet (1 bit) SHALL exist and chime_trig SHALL be ignored while quiet=1; alarms unaffected.
REQ-030 Without BEEP_SEQUENCER_QUIET_EN, port quiet SHALL be absent and all chimes SHALL run.

Structure
REQ-031 A shared package SHALL hold the state-encoding constants (IDLE, ON, OFF), the 12 hour-map constant and the 8-bit count width.
REQ-032 One sub-module beep_phase_timer (tick counter, terminal-count output, clear input) SHALL be instantiated.

Verification
REQ-033 chime_trig, hour=3, ON_TICKS=OFF_TICKS=2 -> exactly 3 beep pulses, beep_enabled high for 2 ticks each, busy low after 3rd OFF.
REQ-034 chime_trig, hour=0 -> 12 beep pulses; hour=13 -> 12 beep pulses.
REQ-035 alarm_trig, ALARM_BEEPS=5 -> 5 pulses, alarm_active high throughout, low when IDLE reached.
REQ-036 chime hour=6 running, alarm_trig after 2nd beep -> beep pulse next cycle, alarm_active=1, 5 further beeps (ALARM_BEEPS=5).
REQ-037 alarm running, stop and chime_trig same cycle -> IDLE next cycle, no beep, busy=0.
REQ-038 rst asserted during ON -> next cycle all outputs 0; with QUIET_EN and quiet=1, chime_trig -> busy stays 0.
